// File: rtl/blk_classifier.sv
// blk_classifier: classifies KHxKV pixel blocks of a raster stream as dark or
// light with hysteresis, drives a per-pixel block flag and counts dark blocks.
module blk_classifier #(
  parameter int HP       = 1920,
  parameter int VP       = 1080,
  parameter int KH       = 30,
  parameter int KV       = 30,
  parameter int NCH      = 3,
  parameter int CW       = 8,
  parameter int TH_DARK  = 150,
  parameter int TH_LIGHT = 240
) (
  input  logic                                 vin_clk_i,
  input  logic                                 rst_ni,
  input  logic [1:0]                           mode_i,
  input  logic                                 freeze_i,
  input  logic                                 vin_hs_i,
  input  logic                                 vin_vs_i,
  input  logic                                 vin_de_i,
  input  logic [NCH*CW-1:0]                    vin_data_i,
  output logic                                 blk_o,
  output logic [$clog2((HP/KH)*(VP/KV)+1)-1:0] dark_cnt_o,
  output logic                                 frame_done_o,
  output logic                                 busy_o
);
  localparam int HBLKS = HP / KH;
  localparam int VBLKS = VP / KV;
  localparam int NBLK  = HBLKS * VBLKS;
  localparam int LW    = CW + $clog2(NCH);
  localparam int AW    = $clog2(KH*KV*NCH*(2**CW-1)+1);
  localparam int CNTW  = $clog2(NBLK+1);
  localparam int PXW   = $clog2(HP+1);
  localparam int LNW   = $clog2(VP+1);
  localparam int CIW   = (HBLKS > 1) ? $clog2(HBLKS) : 1;
  localparam int RW    = (VBLKS > 1) ? $clog2(VBLKS) : 1;
  localparam int BIW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [31:0] TDK = 32'(TH_DARK*KH*KV);
  localparam logic [31:0] TLK = 32'(TH_LIGHT*KH*KV);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_COMMIT = 1'b1;

  if (HP % KH != 0) begin : g_bad_hp
    $error("blk_classifier: HP must be a multiple of KH");
  end
  if (VP % KV != 0) begin : g_bad_vp
    $error("blk_classifier: VP must be a multiple of KV");
  end
  if (TH_DARK > TH_LIGHT) begin : g_bad_th
    $error("blk_classifier: TH_DARK must not exceed TH_LIGHT");
  end

  // Lines are delimited by DE alone; HS carries no extra information here.
  logic unused_hs;
  assign unused_hs = vin_hs_i;

  logic            de_d, vs_d, de_rise, de_fall, vs_rise;
  logic [LW-1:0]   luma;
  logic [PXW-1:0]  px_q, px_cur, pcol;
  logic [LNW-1:0]  ln_q, prow;
  logic            pix_ok, pbit, sel;
  logic [BIW-1:0]  pidx, cidx;
  logic [AW-1:0]   acc [HBLKS];
  logic [AW-1:0]   csum;
  logic [NBLK-1:0] dbits;
  logic [0:0]      state;
  logic [CIW-1:0]  ci;
  logic [RW-1:0]   crow;
  logic            abort_q, start, last, last_row;
  logic            old_bit, new_bit, kept_bit;
  logic [CNTW-1:0] run_cnt;

  // Luma: full-width sum of all channels.
  always_comb begin
    luma = '0;
    for (int k = 0; k < NCH; k++) luma = luma + LW'(vin_data_i[k*CW +: CW]);
  end

  // Pixel position and the decision bit it maps to.
  always_comb begin
    de_rise = vin_de_i & ~de_d;
    de_fall = ~vin_de_i & de_d;
    vs_rise = vin_vs_i & ~vs_d;
    px_cur  = de_rise ? '0 : px_q;
    pix_ok  = vin_de_i && (px_cur < PXW'(HP)) && (ln_q < LNW'(VP));
    pcol    = px_cur / PXW'(KH);
    prow    = ln_q / LNW'(KV);
    pidx    = BIW'(int'(prow) * HBLKS + int'(pcol));
    pbit    = dbits[pidx];
  end

  // Commit step: threshold with hysteresis; freeze keeps the stored bit.
  always_comb begin
    start    = (state == S_IDLE) && de_fall && !vs_rise && (ln_q < LNW'(VP)) &&
               (ln_q % LNW'(KV) == LNW'(KV-1));
    cidx     = BIW'(int'(crow) * HBLKS + int'(ci));
    csum     = acc[ci];
    old_bit  = dbits[cidx];
    new_bit  = (32'(csum) < TDK) ? 1'b1 : (32'(csum) >= TLK) ? 1'b0 : old_bit;
    kept_bit = freeze_i ? old_bit : new_bit;
    last     = (ci == CIW'(HBLKS-1));
    last_row = (crow == RW'(VBLKS-1));
  end

  // Output flag selection by mode.
  always_comb begin
    sel = 1'b0;
    case (mode_i)
      2'b00:   sel = 1'b0;
      2'b01:   sel = 1'b1;
      2'b10:   sel = pbit;
      default: sel = ~pbit;
    endcase
  end

  // Edge history plus saturating pixel and line counters.
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_d <= 1'b0;
      vs_d <= 1'b0;
      px_q <= '0;
      ln_q <= '0;
    end else begin
      de_d <= vin_de_i;
      vs_d <= vin_vs_i;
      if (vin_de_i) px_q <= (px_cur < PXW'(HP)) ? px_cur + 1'b1 : px_cur;
      if (vs_rise)                             ln_q <= '0;
      else if (de_fall && ln_q < LNW'(VP))     ln_q <= ln_q + 1'b1;
    end
  end

  // Column accumulators; a pixel landing on the column being committed
  // starts the new sum instead of being lost.
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < HBLKS; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < HBLKS; i++) begin
        if (vs_rise)
          acc[i] <= '0;
        else if (state == S_COMMIT && ci == CIW'(i))
          acc[i] <= (pix_ok && pcol == PXW'(i)) ? AW'(luma) : '0;
        else if (pix_ok && pcol == PXW'(i))
          acc[i] <= acc[i] + AW'(luma);
      end
    end
  end

  // Commit FSM: walks one column per cycle after the last line of a block row.
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      ci      <= '0;
      crow    <= '0;
      abort_q <= 1'b0;
    end else begin
      if (vs_rise)    abort_q <= 1'b1;
      else if (start) abort_q <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          state <= S_COMMIT;
          ci    <= '0;
          crow  <= RW'(prow);
        end
      end else begin
        if (last) state <= S_IDLE;
        ci <= last ? '0 : ci + 1'b1;
      end
    end
  end

  // Decision memory, running dark count and end-of-frame publish.
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbits        <= '0;
      run_cnt      <= '0;
      dark_cnt_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (state == S_COMMIT && !freeze_i) dbits[cidx] <= new_bit;
      if (vs_rise) begin
        run_cnt <= '0;
      end else if (state == S_COMMIT && !abort_q) begin
        if (last && last_row) begin
          run_cnt      <= '0;
          dark_cnt_o   <= run_cnt + CNTW'(kept_bit);
          frame_done_o <= 1'b1;
        end else begin
          run_cnt <= run_cnt + CNTW'(kept_bit);
        end
      end
    end
  end

  // Registered per-pixel flag, forced low outside the active window.
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) blk_o <= 1'b0;
    else         blk_o <= pix_ok & sel;
  end

  assign busy_o = (state == S_COMMIT);

endmodule

// File: doc/blk_classifier.md
BLK_CLASSIFIER -- requirements
Module: blk_classifier

Interface
REQ-001 Parameters: HP 1920, active pixels per line; VP 1080, active lines per frame; KH 30, block width in pixels; KV 30, block height in lines; NCH 3, channels per pixel; CW 8, bits per channel; TH_DARK 150, per-pixel luma below which a block becomes dark; TH_LIGHT 240, per-pixel luma at or above which a block becomes light.
REQ-002 Derived values: HBLKS=HP/KH, VBLKS=VP/KV, NBLK=HBLKS*VBLKS; HP%KH==0, VP%KV==0 and TH_DARK<=TH_LIGHT SHALL be enforced by elaboration-time checks.
REQ-003 vin_clk_i  in  1  sole clock; all logic is rising-edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 mode_i  in  2  output mode: 00 off, 01 force, 10 per-block, 11 per-block inverted.
REQ-006 freeze_i  in  1  1 = block decision memory is not updated.
REQ-007 vin_hs_i, vin_vs_i, vin_de_i  in  1 each  video timing, active high.
REQ-008 vin_data_i  in  NCH*CW  pixel; channel k at bits [k*CW +: CW].
REQ-009 blk_o  out  1  registered per-pixel dark flag.
REQ-010 dark_cnt_o  out  clog2(NBLK+1)  dark blocks in the last completed frame.
REQ-011 frame_done_o  out  1  one-cycle pulse when dark_cnt_o updates.
REQ-012 busy_o  out  1  high while the commit FSM is in COMMIT.

Function
REQ-013 Pixel luma SHALL be the unsigned sum of the NCH channels, width CW+clog2(NCH), with no truncation.
REQ-014 Pixel counter px SHALL clear on vin_de_i rising edge and increment per DE pixel; line counter ln SHALL increment on DE falling edge and clear on vin_vs_i rising edge.
REQ-015 Pixels with px>=HP or ln>=VP SHALL be ignored by the accumulators and SHALL produce blk_o=0.
REQ-016 HBLKS accumulators, each clog2(KH*KV*NCH*(2^CW-1)+1) bits wide, SHALL sum the luma of block column px/KH across the KV lines of the current block row.
REQ-017 On the DE falling edge of a line with ln%KV==KV-1, the FSM SHALL go IDLE->COMMIT and process index i=0..HBLKS-1 at one index per cycle, then return to IDLE.
REQ-018 In COMMIT, for each index i: sum<TH_DARK*KH*KV sets decision bit (row,i)=1; sum>=TH_LIGHT*KH*KV clears it to 0; otherwise the bit holds its value. The accumulator then clears.
REQ-019 While freeze_i=1, COMMIT SHALL NOT write the decision bits, but the accumulators SHALL still clear.
REQ-020 Each COMMIT step SHALL add the resulting stored bit (row,i) to a running frame count.
REQ-021 One cycle after the final COMMIT index of block row VBLKS-1, dark_cnt_o SHALL load the running count and frame_done_o SHALL pulse; the running count SHALL then clear.
REQ-022 blk_o SHALL be registered with one cycle of latency from the sampled pixel: mode 00 -> 0; mode 01 -> 1; mode 10 -> bit(ln/KV, px/KH); mode 11 -> its inverse; 0 whenever vin_de_i=0.
REQ-023 A vin_vs_i rising edge SHALL clear the accumulators and the running count, abandoning the partial frame. A COMMIT already in progress SHALL finish its row, but no frame_done_o pulse SHALL follow.
REQ-024 A frame with fewer than VP lines SHALL NOT update dark_cnt_o.
REQ-025 The integrator SHALL guarantee that horizontal blanking is at least HBLKS+2 cycles. If DE rises during COMMIT, pixels SHALL still accumulate, because COMMIT clears index i before DE can reach that column.

Reset
REQ-026 Reset SHALL clear blk_o, dark_cnt_o, frame_done_o, busy_o, all decision bits (light), the accumulators and the counters, and SHALL put the FSM in IDLE, including when reset is asserted mid-COMMIT.

Verification
(Parameters: HP=8, VP=4, KH=4, KV=2, NCH=3, CW=8, TH_DARK=100, TH_LIGHT=200; 4 blocks; thresholds 800/1600 per block sum.)
REQ-027 Reset, then mode 10 with an all-0xFFFFFF frame -> blk_o=0 on every pixel, dark_cnt_o=0, one frame_done_o pulse after the last row commit, busy_o high for 2 cycles per row commit.
REQ-028 Frame of 0x000000, then mode 10 -> dark_cnt_o=4; on the next frame blk_o=1 one cycle after every DE pixel; mode 11 -> 0; mode 00 -> 0; mode 01 -> 1.
REQ-029 Hysteresis: after an all-dark frame, send luma 150 (0x323232) -> dark_cnt_o stays 4; then luma 210 (0x464646) -> dark_cnt_o=0; then luma 150 -> stays 0.
REQ-030 Mixed frame: left 4 columns 0x000000, right 4 columns 0xFFFFFF -> dark_cnt_o=2; the next frame, mode 10, gives blk_o=1 only for px 0-3.
REQ-031 freeze_i=1 for a bright frame after a dark frame -> dark_cnt_o=4 and blk_o stays 1; after freeze_i=0 and one bright frame -> dark_cnt_o=0.
REQ-032 vin_vs_i rises after 2 lines -> no frame_done_o and dark_cnt_o unchanged; rst_ni pulsed mid-COMMIT -> all outputs and bits 0, and the next full frame behaves as in REQ-027.
